// File: rtl/true_dual_port_ram.sv
// Two-port synchronous RAM: port A read/write with per-lane write mask, port B read-only.
// Both read paths are registered, read-first, and cleared by the synchronous reset.
module true_dual_port_ram #(
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned MEM_WIDTH          = 32,
    parameter int unsigned WRITE_STROBE_WIDTH = 8,
    parameter              MEMORY_PRIMITIVE   = "block"
) (
    input  logic                                      aclk,
    input  logic                                      resetn,
    input  logic [MEM_WIDTH-1:0]                      writeData,
    input  logic                                      write,
    input  logic [ADDR_WIDTH-1:0]                     writeAddr,
    input  logic [MEM_WIDTH/WRITE_STROBE_WIDTH-1:0]   writeMask,
    output logic [MEM_WIDTH-1:0]                      writeDataOut,
    output logic [MEM_WIDTH-1:0]                      readData,
    input  logic [ADDR_WIDTH-1:0]                     readAddr
);

    localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES          = MEM_WIDTH / WRITE_STROBE_WIDTH;
    localparam bit          IS_DISTRIBUTED = (MEMORY_PRIMITIVE == "distributed");

    logic [LANES-1:0]     laneWrite;
    logic [MEM_WIDTH-1:0] memWordA;
    logic [MEM_WIDTH-1:0] memWordB;

    // Lane enables: a write in a reset cycle is dropped entirely.
    always_comb begin
        laneWrite = {LANES{1'b0}};
        if (resetn && write) begin
            laneWrite = writeMask;
        end else begin
            laneWrite = {LANES{1'b0}};
        end
    end

    // The primitive choice only changes the inference hint; behaviour is identical.
    if (IS_DISTRIBUTED) begin : gDistributed
        (* ram_style = "distributed" *)
        logic [MEM_WIDTH-1:0] mem [DEPTH] = '{default: {MEM_WIDTH{1'b0}}};

        // Masked lane writes on port A.
        always_ff @(posedge aclk) begin
            for (int i = 0; i < LANES; i++) begin
                if (laneWrite[i]) begin
                    mem[writeAddr][i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH]
                        <= writeData[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
                end
            end
        end

        assign memWordA = mem[writeAddr];
        assign memWordB = mem[readAddr];
    end else begin : gBlock
        (* ram_style = "block" *)
        logic [MEM_WIDTH-1:0] mem [DEPTH] = '{default: {MEM_WIDTH{1'b0}}};

        // Masked lane writes on port A.
        always_ff @(posedge aclk) begin
            for (int i = 0; i < LANES; i++) begin
                if (laneWrite[i]) begin
                    mem[writeAddr][i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH]
                        <= writeData[i*WRITE_STROBE_WIDTH +: WRITE_STROBE_WIDTH];
                end
            end
        end

        assign memWordA = mem[writeAddr];
        assign memWordB = mem[readAddr];
    end

    // Output registers sample the pre-write word, giving read-first on both ports.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            writeDataOut <= {MEM_WIDTH{1'b0}};
            readData     <= {MEM_WIDTH{1'b0}};
        end else begin
            writeDataOut <= memWordA;
            readData     <= memWordB;
        end
    end

endmodule

// File: tb/tb_true_dual_port_ram.sv
// Directed plus randomized bench for true_dual_port_ram against an array reference model.
module tb_true_dual_port_ram;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int SW = 16;
    localparam int LN = DW / SW;

    logic          aclk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] writeData = '0;
    logic          write = 1'b0;
    logic [AW-1:0] writeAddr = '0;
    logic [LN-1:0] writeMask = '0;
    logic [DW-1:0] writeDataOut;
    logic [DW-1:0] readData;
    logic [AW-1:0] readAddr = '0;

    logic [DW-1:0] refMem [2**AW];
    int checks = 0;
    int errors = 0;

    true_dual_port_ram #(
        .ADDR_WIDTH(AW), .MEM_WIDTH(DW), .WRITE_STROBE_WIDTH(SW), .MEMORY_PRIMITIVE("block")
    ) dut (
        .aclk(aclk), .resetn(resetn), .writeData(writeData), .write(write),
        .writeAddr(writeAddr), .writeMask(writeMask), .writeDataOut(writeDataOut),
        .readData(readData), .readAddr(readAddr)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict outputs from the model, advance, compare.
    task automatic cycle(input logic rst, input logic wr, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [LN-1:0] wm,
                         input logic [AW-1:0] ra, input string tag);
        logic [DW-1:0] expA, expB, bitMask;
        resetn = rst; write = wr; writeAddr = wa; writeData = wd; writeMask = wm; readAddr = ra;
        expA = rst ? refMem[wa] : '0;
        expB = rst ? refMem[ra] : '0;
        if (rst && wr) begin
            bitMask = '0;
            for (int i = 0; i < LN; i++)
                if (wm[i]) bitMask = bitMask | (((DW'(1) << SW) - DW'(1)) << (i * SW));
            refMem[wa] = (refMem[wa] & ~bitMask) | (wd & bitMask);
        end
        @(posedge aclk);
        #1;
        chk({tag, ".A"}, writeDataOut, expA);
        chk({tag, ".B"}, readData, expB);
    endtask

    initial begin
        logic [DW-1:0] savedAddr2;
        for (int i = 0; i < 2**AW; i++) refMem[i] = '0;

        cycle(1'b0, 1'b0, 4'd0, 32'h0, 2'b00, 4'd0, "reset0");
        cycle(1'b0, 1'b0, 4'd0, 32'h0, 2'b00, 4'd0, "reset1");
        chk("resetOutA", writeDataOut, 32'h0);
        chk("resetOutB", readData, 32'h0);

        // Basic write/read
        cycle(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 2'b11, 4'd0, "basicWr");
        cycle(1'b1, 1'b0, 4'd3, 32'h0, 2'b00, 4'd3, "basicRd");
        chk("basicB", readData, 32'hDEADBEEF);
        chk("basicA", writeDataOut, 32'hDEADBEEF);

        // Masked writes
        cycle(1'b1, 1'b1, 4'd5, 32'h11112222, 2'b11, 4'd0, "maskInit");
        cycle(1'b1, 1'b1, 4'd5, 32'hAAAABBBB, 2'b01, 4'd0, "maskLo");
        cycle(1'b1, 1'b0, 4'd5, 32'h0, 2'b00, 4'd5, "maskRd");
        chk("maskLoB", readData, 32'h1111BBBB);
        cycle(1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 2'b00, 4'd0, "maskNone");
        cycle(1'b1, 1'b0, 4'd5, 32'h0, 2'b00, 4'd5, "maskNoneRd");
        chk("maskNoneB", readData, 32'h1111BBBB);
        chk("maskNoneA", writeDataOut, 32'h1111BBBB);

        // Read-first on port A, then cross-port collision
        cycle(1'b1, 1'b1, 4'd7, 32'h12345678, 2'b11, 4'd0, "rfInit");
        cycle(1'b1, 1'b1, 4'd7, 32'hCAFEF00D, 2'b11, 4'd0, "rfWr");
        chk("readFirstA", writeDataOut, 32'h12345678);
        cycle(1'b1, 1'b1, 4'd7, 32'h0BADBEEF, 2'b11, 4'd7, "collide");
        chk("readFirstA2", writeDataOut, 32'hCAFEF00D);
        chk("collideB", readData, 32'hCAFEF00D);
        cycle(1'b1, 1'b0, 4'd7, 32'h0, 2'b00, 4'd7, "collideAfter");
        chk("collideAfterB", readData, 32'h0BADBEEF);

        // Streaming writes with port B one cycle behind, then reverse readback
        for (int i = 0; i <= 16; i++)
            cycle(1'b1, i < 16, AW'(i), DW'(i) * 32'h01010101, 2'b11, AW'(i - 1), "stream");
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, AW'(i), 32'h0, 2'b00, AW'(15 - i), "streamRd");
            chk("streamB", readData, DW'(15 - i) * 32'h01010101);
            chk("streamA", writeDataOut, DW'(i) * 32'h01010101);
        end

        // Reset with an in-flight write that must be dropped
        savedAddr2 = refMem[2];
        cycle(1'b0, 1'b1, 4'd2, 32'hFFFFFFFF, 2'b11, 4'd2, "rstWr0");
        cycle(1'b0, 1'b1, 4'd2, 32'hFFFFFFFF, 2'b11, 4'd2, "rstWr1");
        cycle(1'b1, 1'b0, 4'd2, 32'h0, 2'b00, 4'd2, "rstAfter");
        chk("rstKeepB", readData, savedAddr2);
        chk("rstKeepConst", readData, 32'h02020202);

        // Randomized traffic with occasional reset cycles
        for (int n = 0; n < 400; n++)
            cycle(($urandom_range(0, 19) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
                  LN'($urandom), AW'($urandom), "random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
